// File: rtl/contador_timer_bcd_if.sv
// Bundle for the BCD countdown timer core (contador_timer_bcd).
// The clock and reset are not part of this bundle; they stay plain module ports.
//
// Signals, named from the timer's point of view:
//   Control in:  tick_1hz, load, set_HH/MM/SS (BCD), start, stop, ack_end.
//   Status out:  digit{1,0}_{HH,MM,SS}_T (tens/units), timer_end, running,
//                load_err, end_blink.
//
// Modports:
//   master: upstream config/RTC logic plus the display side (drives the
//           controls, reads the status).
//   slave:  the timer core itself.
interface contador_timer_bcd_if;
  logic       tick_1hz;
  logic       load;
  logic [7:0] set_HH;
  logic [7:0] set_MM;
  logic [7:0] set_SS;
  logic       start;
  logic       stop;
  logic       ack_end;

  logic [3:0] digit0_HH_T;
  logic [3:0] digit1_HH_T;
  logic [3:0] digit0_MM_T;
  logic [3:0] digit1_MM_T;
  logic [3:0] digit0_SS_T;
  logic [3:0] digit1_SS_T;
  logic       timer_end;
  logic       running;
  logic       load_err;
  logic       end_blink;

  modport master (
    output tick_1hz, load, set_HH, set_MM, set_SS, start, stop, ack_end,
    input  digit0_HH_T, digit1_HH_T, digit0_MM_T, digit1_MM_T,
           digit0_SS_T, digit1_SS_T, timer_end, running, load_err, end_blink
  );

  modport slave (
    input  tick_1hz, load, set_HH, set_MM, set_SS, start, stop, ack_end,
    output digit0_HH_T, digit1_HH_T, digit0_MM_T, digit1_MM_T,
           digit0_SS_T, digit1_SS_T, timer_end, running, load_err, end_blink
  );
endinterface

// File: rtl/contador_timer_bcd.sv
// HH:MM:SS countdown timer held as six BCD digits, decremented once per tick_1hz
// while running. It feeds the display frame generator.
//
// Ports:
//   clk   - system clock.
//   reset - asynchronous active-high reset. It clears all outputs and returns to IDLE.
//   bus   - contador_timer_bcd_if.slave, which carries the control inputs and the
//           registered status/digit outputs.
//
// Parameter:
//   MAX_HH - the largest hour value (binary) that a load accepts.
//
// Optional build macro TIMER_BLINK_EN:
//   Defined:   end_blink toggles on every tick while in DONE. The first tick sets it.
//              It is held at 0 whenever timer_end is 0.
//   Undefined: end_blink is a direct copy of the timer_end register.
//
// Per-cycle command priority: load > stop > start > tick_1hz. A load that is
// rejected still takes its cycle, so every other command in that cycle is dropped.
module contador_timer_bcd #(
  parameter int unsigned MAX_HH = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  contador_timer_bcd_if.slave  bus
);

  localparam logic [7:0] MaxHhVal = 8'(MAX_HH);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] hh_t_q, hh_u_q, mm_t_q, mm_u_q, ss_t_q, ss_u_q;
  logic [3:0] hh_t_d, hh_u_d, mm_t_d, mm_u_d, ss_t_d, ss_u_d;
  logic       timer_end_q, timer_end_d;
  logic       running_q, running_d;
  logic       load_err_q, load_err_d;

  // Load validation
  logic [7:0] set_hh_bin;
  logic       load_ok;

  always_comb begin
    set_hh_bin = 8'(bus.set_HH[7:4]) * 8'd10 + 8'(bus.set_HH[3:0]);
    load_ok    = (bus.set_HH[7:4] <= 4'd9) && (bus.set_HH[3:0] <= 4'd9) &&
                 (bus.set_MM[7:4] <= 4'd5) && (bus.set_MM[3:0] <= 4'd9) &&
                 (bus.set_SS[7:4] <= 4'd5) && (bus.set_SS[3:0] <= 4'd9) &&
                 (set_hh_bin <= MaxHhVal);
  end

  // One-second BCD decrement with a ripple borrow from seconds to hours.
  // The result is used only in RUN, where the value is never 00:00:00,
  // so the hour tens digit never underflows.
  logic [3:0] dec_hh_t, dec_hh_u, dec_mm_t, dec_mm_u, dec_ss_t, dec_ss_u;
  logic       brw_ss_u, brw_ss_t, brw_mm_u, brw_mm_t, brw_hh_u;
  logic       dec_zero;
  logic       value_nonzero;

  always_comb begin
    brw_ss_u = (ss_u_q == 4'd0);
    dec_ss_u = brw_ss_u ? 4'd9 : ss_u_q - 4'd1;

    brw_ss_t = brw_ss_u && (ss_t_q == 4'd0);
    dec_ss_t = ss_t_q;
    if (brw_ss_u) dec_ss_t = (ss_t_q == 4'd0) ? 4'd5 : ss_t_q - 4'd1;

    brw_mm_u = brw_ss_t && (mm_u_q == 4'd0);
    dec_mm_u = mm_u_q;
    if (brw_ss_t) dec_mm_u = (mm_u_q == 4'd0) ? 4'd9 : mm_u_q - 4'd1;

    brw_mm_t = brw_mm_u && (mm_t_q == 4'd0);
    dec_mm_t = mm_t_q;
    if (brw_mm_u) dec_mm_t = (mm_t_q == 4'd0) ? 4'd5 : mm_t_q - 4'd1;

    // Hours form a plain two-digit BCD number. Units wrap 0 -> 9.
    brw_hh_u = brw_mm_t && (hh_u_q == 4'd0);
    dec_hh_u = hh_u_q;
    if (brw_mm_t) dec_hh_u = (hh_u_q == 4'd0) ? 4'd9 : hh_u_q - 4'd1;

    dec_hh_t = hh_t_q;
    if (brw_hh_u) dec_hh_t = hh_t_q - 4'd1;

    dec_zero      = ~|{dec_hh_t, dec_hh_u, dec_mm_t, dec_mm_u, dec_ss_t, dec_ss_u};
    value_nonzero = |{hh_t_q, hh_u_q, mm_t_q, mm_u_q, ss_t_q, ss_u_q};
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    hh_t_d      = hh_t_q;
    hh_u_d      = hh_u_q;
    mm_t_d      = mm_t_q;
    mm_u_d      = mm_u_q;
    ss_t_d      = ss_t_q;
    ss_u_d      = ss_u_q;
    timer_end_d = timer_end_q;
    running_d   = running_q;
    load_err_d  = 1'b0;

    if (bus.load) begin
      if (load_ok) begin
        hh_t_d      = bus.set_HH[7:4];
        hh_u_d      = bus.set_HH[3:0];
        mm_t_d      = bus.set_MM[7:4];
        mm_u_d      = bus.set_MM[3:0];
        ss_t_d      = bus.set_SS[7:4];
        ss_u_d      = bus.set_SS[3:0];
        state_d     = StIdle;
        timer_end_d = 1'b0;
        running_d   = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle, StPause: begin
          // A stop in this cycle outranks the start, even though the stop does nothing here.
          if (!bus.stop && bus.start && value_nonzero) begin
            state_d   = StRun;
            running_d = 1'b1;
          end
        end
        StRun: begin
          if (bus.stop) begin
            state_d   = StPause;
            running_d = 1'b0;
          end else if (bus.tick_1hz) begin
            hh_t_d = dec_hh_t;
            hh_u_d = dec_hh_u;
            mm_t_d = dec_mm_t;
            mm_u_d = dec_mm_u;
            ss_t_d = dec_ss_t;
            ss_u_d = dec_ss_u;
            if (dec_zero) begin
              state_d     = StDone;
              timer_end_d = 1'b1;
              running_d   = 1'b0;
            end
          end
        end
        StDone: begin
          if (bus.ack_end) begin
            state_d     = StIdle;
            timer_end_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      hh_t_q      <= 4'd0;
      hh_u_q      <= 4'd0;
      mm_t_q      <= 4'd0;
      mm_u_q      <= 4'd0;
      ss_t_q      <= 4'd0;
      ss_u_q      <= 4'd0;
      timer_end_q <= 1'b0;
      running_q   <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hh_t_q      <= hh_t_d;
      hh_u_q      <= hh_u_d;
      mm_t_q      <= mm_t_d;
      mm_u_q      <= mm_u_d;
      ss_t_q      <= ss_t_d;
      ss_u_q      <= ss_u_d;
      timer_end_q <= timer_end_d;
      running_q   <= running_d;
      load_err_q  <= load_err_d;
    end
  end

`ifdef TIMER_BLINK_EN
  logic blink_q, blink_d;

  // The blink flag is cleared whenever timer_end is about to be 0. It therefore
  // enters DONE at 0, and the first tick in DONE sets it.
  always_comb begin
    blink_d = blink_q;
    if (!timer_end_d) begin
      blink_d = 1'b0;
    end else if (state_q == StDone && bus.tick_1hz) begin
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign bus.end_blink = blink_q;
`else
  assign bus.end_blink = timer_end_q;
`endif

  assign bus.digit1_HH_T = hh_t_q;
  assign bus.digit0_HH_T = hh_u_q;
  assign bus.digit1_MM_T = mm_t_q;
  assign bus.digit0_MM_T = mm_u_q;
  assign bus.digit1_SS_T = ss_t_q;
  assign bus.digit0_SS_T = ss_u_q;
  assign bus.timer_end   = timer_end_q;
  assign bus.running     = running_q;
  assign bus.load_err    = load_err_q;

endmodule

// File: doc/contador_timer_bcd.md
Name: contador_timer_bcd

Overview:
- Countdown timer core for the clock/timer display path.
- Holds an HH:MM:SS timer value as BCD digits and decrements it once per 1 Hz tick.
- Drives the digitX_HH_T/MM_T/SS_T nibbles and the timer_end flag that the display frame generator renders.
- Sits between the configuration/RTC interface (upstream, supplies set values and tick) and the display frame logic (downstream).

Parameters:
- MAX_HH, 23, largest hour value accepted on load (binary value of the BCD hour field).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- tick_1hz, input, 1, one-clk-wide pulse once per second.
- load, input, 1, one-clk pulse: capture set_HH/set_MM/set_SS.
- set_HH, input, 8, BCD hours ([7:4] tens, [3:0] units).
- set_MM, input, 8, BCD minutes.
- set_SS, input, 8, BCD seconds.
- start, input, 1, one-clk pulse: begin or resume the countdown.
- stop, input, 1, one-clk pulse: pause the countdown.
- ack_end, input, 1, one-clk pulse: clear timer_end.
- digit0_HH_T, digit1_HH_T, output, 4 each, hour units / tens.
- digit0_MM_T, digit1_MM_T, output, 4 each, minute units / tens.
- digit0_SS_T, digit1_SS_T, output, 4 each, second units / tens.
- timer_end, output, 1, level flag: countdown reached 00:00:00.
- running, output, 1, high while in RUN.
- load_err, output, 1, one-clk pulse: load rejected.
- end_blink, output, 1, alarm blink for display (see Optional Feature).

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-high.
- All outputs are registered.
- Reset value of every output is 0 (all digits 0, timer_end=0, running=0, load_err=0, end_blink=0). State=IDLE.
- Digit convention: digit1 = tens, digit0 = units.
- States: IDLE, RUN, PAUSE, DONE.
- Command precedence, per cycle: reset > load > stop > start > tick_1hz. Lower-priority inputs in the same cycle are ignored.
- Load validation:
  - Every nibble must be <= 9.
  - Minute and second tens must be <= 5.
  - Hour value (tens*10 + units) must be <= MAX_HH.
- Valid load, accepted in any state including RUN:
  - Digits update on the next edge.
  - State becomes IDLE; timer_end clears.
- Invalid load:
  - Digits and state unchanged.
  - load_err=1 for exactly one cycle.
- start:
  - IDLE or PAUSE, value nonzero: go to RUN; running=1 on the next edge.
  - Value 00:00:00: ignored.
  - Ignored in RUN and DONE.
- stop:
  - RUN -> PAUSE; running=0.
  - Ignored in other states.
  - stop coincident with tick: no decrement.
- Decrement, on tick_1hz in RUN:
  - SS units decrement. On 0 it borrows: units become 9 and SS tens decrements.
  - SS tens wrap 0 -> 5 with a borrow to MM. MM follows the same rule; its borrow goes to HH.
  - HH decrements as a two-digit BCD value (units 0 -> 9 with a borrow to tens).
  - Decrement latency: 1 clk after the tick edge.
- Terminal count:
  - The tick that takes 00:00:01 -> 00:00:00 moves the state to DONE.
  - timer_end=1 and running=0 on that same edge.
  - The counter never wraps below zero.
- DONE:
  - Digits hold 00:00:00; timer_end holds.
  - ack_end clears timer_end and moves to IDLE.
  - A valid load also clears timer_end.
  - start is ignored.
- ack_end outside DONE: no effect.
- tick_1hz outside RUN: no effect on the digits.
- Reset asserted mid-count: immediate clear to the reset values, independent of clk.

Optional Feature:
- Macro: TIMER_BLINK_EN.
- Defined:
  - end_blink toggles on each tick_1hz while in DONE.
  - The first tick after entering DONE sets end_blink=1.
  - end_blink forced to 0 whenever timer_end=0.
- Not defined: end_blink = timer_end (combinational copy of the register). No toggle logic is synthesized.

Test Plan:
- Reset then load 00:01:05 (set_MM=8'h01, set_SS=8'h05), start, 6 ticks -> digits 0,0,0,0,5,9 (00:00:59); running=1.
- Load 01:00:00, start, 1 tick -> 00:59:59. Load 10:00:00, start, 1 tick -> 09:59:59 (borrow chains across all fields).
- Load 00:00:02, start, 2 ticks -> 00:00:00, timer_end=1, running=0 on the second tick edge. Further ticks -> still 00:00:00. ack_end -> timer_end=0, state IDLE.
- Invalid loads, each followed by a valid load 00:00:03 first:
  - set_SS=8'h60 -> load_err pulse, digits stay 00:00:03.
  - set_HH=8'h24 (MAX_HH=23) -> load_err pulse, digits stay 00:00:03.
  - set_MM=8'h0A -> load_err pulse, digits stay 00:00:03.
- RUN at 00:00:10, stop and tick in the same cycle -> PAUSE, value stays 00:00:10. Tick while paused -> unchanged. start, tick -> 00:00:09.
- Assert reset asynchronously (between clk edges) while in RUN at 00:30:00 -> all outputs 0 before the next clk edge.
- With TIMER_BLINK_EN, reach DONE, 3 ticks -> end_blink 1,0,1. Without the macro -> end_blink tracks timer_end.
